// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: FSM state type and default sizes shared by the program loader.
package prog_loader_pkg;
  localparam int DATA_W_DEF = 9;
  localparam int ADDR_W_DEF = 5;
  localparam int DEPTH_DEF  = 32;
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;
endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams instruction words into memory from address 0, holding the core in reset meanwhile.
// Optional running checksum of accepted words when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              hold_n,
  output logic              busy,
  output logic              done,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [DATA_W-1:0] exp_csum,
  output logic [DATA_W-1:0] csum,
  output logic              csum_ok,
`endif
  output logic [ADDR_W:0]   count
);
  localparam logic [ADDR_W:0] DMAX = (ADDR_W+1)'(DEPTH);
  state_t state;
  logic [ADDR_W:0] len_q, len_c, count_nx;
  logic go;
  assign go = start && (state == IDLE || state == DONE);
  assign len_c = len > DMAX ? DMAX : len;
  assign count_nx = count + (ADDR_W+1)'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hold_n    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      len_q     <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE: if (go) begin
          count <= '0;
          len_q <= len_c;
          if (len_c == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= LOAD;
            in_ready <= 1'b1;
            hold_n   <= 1'b0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        // in_ready is always high in LOAD, so in_valid alone marks a transfer
        LOAD: if (in_valid) begin
          mem_we    <= 1'b1;
          mem_addr  <= count[ADDR_W-1:0];
          mem_wdata <= in_data;
          count     <= count_nx;
          if (count_nx == len_q) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end
        end
        FLUSH: begin
          state  <= DONE;
          hold_n <= 1'b1;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] exp_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum  <= '0;
      exp_q <= '0;
    end else if (go) begin
      csum  <= '0;
      exp_q <= exp_csum;
    end else if (state == LOAD && in_valid) begin
      csum <= csum + in_data;
    end
  end
  assign csum_ok = done && csum == exp_q;
`endif
endmodule
